// File: rtl/pwm_gen.sv
// pwm_gen -- single-channel PWM generator with shadowed period/duty.
//
// Purpose:
//   Produces a registered PWM waveform (V_PWM_C) whose period is per_q + 1
//   clock cycles and whose high time is duty_q cycles. Period and duty are
//   captured into shadow registers; while running, new values are staged and
//   only applied on the terminal-count edge so every period is glitch-free.
//   A STOP state lets the current period finish after en drops.
//
// Ports:
//   clk          in   1  clock, all state on rising edge
//   rst          in   1  synchronous active-high reset
//   en           in   1  run request (level)
//   period       in   W  period minus one, in clk cycles
//   duty         in   W  high time, in clk cycles
//   load         in   1  strobe to capture period/duty
//   V_PWM_C      out  1  PWM waveform (registered)
//   period_done  out  1  pulse during the last cycle of each period (registered)
//   busy         out  1  high whenever the block is not IDLE (registered)
module pwm_gen #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty,
    input  logic         load,
    output logic         V_PWM_C,
    output logic         period_done,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Unsigned compare widened by one bit so the largest period value cannot
    // wrap the comparison.
    function automatic logic lt_wide(input logic [W-1:0] a, input logic [W-1:0] b);
        return ({1'b0, a} < {1'b0, b});
    endfunction

    function automatic logic eq_wide(input logic [W-1:0] a, input logic [W-1:0] b);
        return ({1'b0, a} == {1'b0, b});
    endfunction

    state_t       state_r, state_s;
    logic [W-1:0] cnt_r, cnt_s;
    logic [W-1:0] per_q_r, per_q_s;
    logic [W-1:0] duty_q_r, duty_q_s;
    logic [W-1:0] stg_per_r, stg_per_s;
    logic [W-1:0] stg_duty_r, stg_duty_s;
    logic         pending_r, pending_s;
    logic         pwm_r, pwm_s;
    logic         done_r, done_s;
    logic         busy_r, busy_s;
    logic         tc_s;
    logic         running_s;

    // Terminal count: last cycle of the current period while running.
    always_comb begin
        if (state_r != ST_IDLE) begin
            tc_s = eq_wide(cnt_r, per_q_r);
        end else begin
            tc_s = 1'b0;
        end
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {W{1'b0}};
            per_q_r    <= {W{1'b0}};
            duty_q_r   <= {W{1'b0}};
            stg_per_r  <= {W{1'b0}};
            stg_duty_r <= {W{1'b0}};
            pending_r  <= 1'b0;
            pwm_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            per_q_r    <= per_q_s;
            duty_q_r   <= duty_q_s;
            stg_per_r  <= stg_per_s;
            stg_duty_r <= stg_duty_s;
            pending_r  <= pending_s;
            pwm_r      <= pwm_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic. STOP lets the current period run out; re-asserting
    // en in STOP resumes RUN with the counter untouched, so there is no gap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_s = ST_RUN;
                end else if (tc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Counter, shadow and staging registers. In IDLE a load goes straight
    // into the shadows. While running, a load is staged (latest wins) and
    // the shadows change only at terminal count; a load arriving exactly on
    // terminal count bypasses staging and governs the very next period.
    always_comb begin
        cnt_s      = cnt_r;
        per_q_s    = per_q_r;
        duty_q_s   = duty_q_r;
        stg_per_s  = stg_per_r;
        stg_duty_s = stg_duty_r;
        pending_s  = pending_r;
        if (state_r == ST_IDLE) begin
            cnt_s = {W{1'b0}};
            if (load) begin
                per_q_s  = period;
                duty_q_s = duty;
            end else begin
                per_q_s  = per_q_r;
                duty_q_s = duty_q_r;
            end
        end else begin
            if (tc_s) begin
                cnt_s     = {W{1'b0}};
                pending_s = 1'b0;
                if (load) begin
                    per_q_s    = period;
                    duty_q_s   = duty;
                    stg_per_s  = period;
                    stg_duty_s = duty;
                end else if (pending_r) begin
                    per_q_s  = stg_per_r;
                    duty_q_s = stg_duty_r;
                end else begin
                    per_q_s  = per_q_r;
                    duty_q_s = duty_q_r;
                end
            end else begin
                cnt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
                if (load) begin
                    stg_per_s  = period;
                    stg_duty_s = duty;
                    pending_s  = 1'b1;
                end else begin
                    pending_s  = pending_r;
                end
            end
        end
    end

    // Output decode from next-cycle values, so the registered outputs line
    // up with the counter value they describe.
    always_comb begin
        running_s = (state_s != ST_IDLE);
        if (running_s) begin
            pwm_s  = lt_wide(cnt_s, duty_q_s);
            done_s = eq_wide(cnt_s, per_q_s);
            busy_s = 1'b1;
        end else begin
            pwm_s  = 1'b0;
            done_s = 1'b0;
            busy_s = 1'b0;
        end
    end

    assign V_PWM_C     = pwm_r;
    assign period_done = done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen. A vector table holds one record per clock
// (inputs plus the outputs expected after that edge); expectations are
// queued when a record is driven and popped after the edge to compare.
module tb_pwm_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] period;
    logic [7:0] duty;
    logic       load;
    logic       V_PWM_C;
    logic       period_done;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [7:0] period;
        logic [7:0] duty;
        logic       e_pwm;
        logic       e_done;
        logic       e_busy;
        string      name;
    } vec_t;

    typedef struct {
        logic  e_pwm;
        logic  e_done;
        logic  e_busy;
        string name;
        int    idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    pwm_gen #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period      (period),
        .duty        (duty),
        .load        (load),
        .V_PWM_C     (V_PWM_C),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic e, input logic l,
                       input int p, input int d,
                       input logic ep, input logic ed, input logic eb);
        vec_t v;
        v.rst = r; v.en = e; v.load = l;
        v.period = 8'(p); v.duty = 8'(d);
        v.e_pwm = ep; v.e_done = ed; v.e_busy = eb;
        v.name = nm;
        vecs.push_back(v);
    endtask

    // n running cycles with no load; counter after edge k is (start+k) mod (per+1).
    // Live period/duty are randomised to show they are ignored without load.
    task automatic run_cycles(input string nm, input int n, input int start,
                              input int per, input int dty, input logic en_v);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start + k) % (per + 1);
            add(nm, 1'b0, en_v, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                (c < dty), (c == per), 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; load = 1'b0; period = 8'd0; duty = 8'd0;

        // Reset, including reset overriding en and load.
        add("reset", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        add("reset_override", 1'b1, 1'b1, 1'b1, 3, 2, 1'b0, 1'b0, 1'b0);
        add("idle", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Basic: period 3 duty 2 -> 1,1,0,0.
        add("basic_load", 1'b0, 1'b0, 1'b1, 3, 2, 1'b0, 1'b0, 1'b0);
        run_cycles("basic", 12, 0, 3, 2, 1'b1);
        // Stop with en low sampled at cnt=1: finish period then IDLE.
        run_cycles("stop_run", 2, 0, 3, 2, 1'b1);
        run_cycles("stop_tail", 2, 2, 3, 2, 1'b0);
        add("stop_idle", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        add("stop_idle2", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Re-enable during STOP: no gap.
        run_cycles("restart", 1, 0, 3, 2, 1'b1);
        run_cycles("restart_stop", 1, 1, 3, 2, 1'b0);
        run_cycles("restart_nogap", 4, 2, 3, 2, 1'b1);
        run_cycles("restart_tail", 2, 2, 3, 2, 1'b0);
        add("restart_idle", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // 50%: period 39 duty 20 over 5 periods.
        add("half_load", 1'b0, 1'b0, 1'b1, 39, 20, 1'b0, 1'b0, 1'b0);
        run_cycles("half", 200, 0, 39, 20, 1'b1);
        add("half_rst", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Duty extremes.
        add("duty0_load", 1'b0, 1'b0, 1'b1, 7, 0, 1'b0, 1'b0, 1'b0);
        run_cycles("duty0", 16, 0, 7, 0, 1'b1);
        add("duty0_rst", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        add("duty9_load", 1'b0, 1'b0, 1'b1, 7, 9, 1'b0, 1'b0, 1'b0);
        run_cycles("duty9", 16, 0, 7, 9, 1'b1);
        add("duty9_rst", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // One-cycle period.
        add("per0_load", 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
        run_cycles("per0", 4, 0, 0, 1, 1'b1);
        run_cycles("per0_stop", 1, 0, 0, 1, 1'b0);
        add("per0_idle", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        add("per0_rst", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Mid-period reload: 3/1 running, load 5/3 sampled at cnt=1.
        add("reload_load", 1'b0, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0, 1'b0);
        run_cycles("reload_pre", 6, 0, 3, 1, 1'b1);
        add("reload_mid", 1'b0, 1'b1, 1'b1, 5, 3, 1'b0, 1'b0, 1'b1);
        run_cycles("reload_cur", 1, 3, 3, 1, 1'b1);
        run_cycles("reload_new", 12, 0, 5, 3, 1'b1);
        // Load coincident with terminal count applies immediately.
        add("tc_load", 1'b0, 1'b1, 1'b1, 3, 2, 1'b1, 1'b0, 1'b1);
        run_cycles("tc_after", 1, 1, 3, 2, 1'b1);
        // Two loads in one period: the later one wins.
        add("ovr_first", 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
        add("ovr_second", 1'b0, 1'b1, 1'b1, 2, 1, 1'b0, 1'b1, 1'b1);
        run_cycles("ovr_new", 6, 0, 2, 1, 1'b1);

        // Reset at cnt=2, then en without load: shadows are zero.
        add("mid_rst", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_cycles("post_rst", 5, 0, 0, 0, 1'b1);
        add("final_rst", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; load = vecs[i].load;
            period = vecs[i].period; duty = vecs[i].duty;
            e.e_pwm = vecs[i].e_pwm; e.e_done = vecs[i].e_done; e.e_busy = vecs[i].e_busy;
            e.name = vecs[i].name; e.idx = i;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sb_q.pop_front();
            tests_run++;
            if (V_PWM_C !== got.e_pwm || period_done !== got.e_done || busy !== got.e_busy) begin
                tests_failed++;
                $display("FAIL %s vec %0d: got pwm=%b done=%b busy=%b, want pwm=%b done=%b busy=%b",
                         got.name, got.idx, V_PWM_C, period_done, busy,
                         got.e_pwm, got.e_done, got.e_busy);
            end
        end

        @(posedge clk);
        #1;
        tests_run++;
        if (V_PWM_C !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_pwm: got %b, want 0", V_PWM_C);
        end
        tests_run++;
        if (period_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_done: got %b, want 0", period_done);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_busy: got %b, want 0", busy);
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard: got %0d pending entries, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter W, default 8, width of the period, duty and counter fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  run request; level-sensitive.
REQ-005 SHALL have port period  input  W  period minus one, in clk cycles.
REQ-006 SHALL have port duty  input  W  high time, in clk cycles.
REQ-007 SHALL have port load  input  1  one-cycle strobe; requests capture of period/duty.
REQ-008 SHALL have port V_PWM_C  output  1  PWM waveform feeding the downstream two-phase non-overlap generator.
REQ-009 SHALL have port period_done  output  1  one-cycle pulse on the last cycle of each period.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL hold shadow registers per_q and duty_q; the waveform SHALL use only shadow values, never the live inputs.
REQ-012 SHALL, in IDLE, copy period/duty into per_q/duty_q on the edge where load is sampled high.
REQ-013 SHALL, in RUN or STOP, set a pending flag on load and latch the data into staging registers; a later load before application SHALL overwrite the staged values.
REQ-014 SHALL apply staged values to per_q/duty_q on the terminal-count edge (cnt == per_q), so they take effect on cnt = 0 of the next period; pending then clears.
REQ-015 SHALL treat load coincident with terminal count as applying to the immediately following period.
REQ-016 SHALL implement states IDLE, RUN and STOP:
- IDLE to RUN on en = 1, with cnt = 0.
- RUN to STOP on en = 0.
- STOP to RUN on en = 1, without resetting cnt and without a gap.
- STOP to IDLE on the terminal-count edge.
REQ-017 SHALL, in RUN/STOP, increment cnt by 1 each cycle and wrap from per_q to 0; the period is per_q + 1 cycles; no other wrap point exists.
REQ-018 SHALL drive V_PWM_C from a register, high exactly in those period cycles where cnt < duty_q, and low in IDLE.
REQ-019 SHALL produce the first high cycle (when duty_q > 0) in the cycle after en is first sampled high in IDLE.
REQ-020 SHALL give constant-low output for duty_q = 0, and constant-high output for duty_q > per_q while running; compares SHALL be unsigned at W+1 bits, so there is no overflow at per_q = 2^W - 1.
REQ-021 SHALL support per_q = 0 (1-cycle period): output is constant duty_q != 0, and period_done is high every running cycle.
REQ-022 SHALL assert period_done during the cycle cnt == per_q in RUN/STOP only, including the final STOP period.
REQ-023 SHALL ignore changes on period/duty without load.

Reset
REQ-024 SHALL, on rst sampled high, set state = IDLE, cnt = 0, per_q = 0, duty_q = 0, staging = 0, pending = 0, V_PWM_C = 0, period_done = 0, busy = 0, overriding en and load in the same cycle.
REQ-025 SHALL abort an in-progress period on reset mid-operation, with no completion pulse; operation resumes only via a new en after rst deasserts.

Verification
REQ-026 SHALL cover basic operation: load period = 3, duty = 2 in IDLE, then en = 1 -> V_PWM_C 1,1,0,0 repeating; period_done on every 4th cycle; busy = 1.
REQ-027 SHALL cover the 50% case matching the downstream 40-cycle clock: period = 39, duty = 20 -> 20 high / 20 low cycles per period, verified over 5 periods.
REQ-028 SHALL cover duty extremes: period = 7 with duty = 0 -> V_PWM_C constantly 0; with duty = 9 -> constantly 1; period_done every 8 cycles in both cases.
REQ-029 SHALL cover mid-period reload: running period = 3, duty = 1; load period = 5, duty = 3 at cnt = 1 -> current period completes as 1,0,0,0, then 1,1,1,0,0,0 repeating.
REQ-030 SHALL cover stop and restart: en = 0 at cnt = 1 of period = 3 -> period finishes, period_done on cnt = 3, then IDLE, V_PWM_C = 0, busy = 0; a separate run with en reasserted during STOP -> no gap in the waveform.
REQ-031 SHALL cover reset mid-operation: rst = 1 at cnt = 2 -> next cycle all outputs 0, state IDLE, per_q = duty_q = 0; en = 1 without load -> V_PWM_C stays 0, period_done is high every cycle.
